// File: rtl/process_scheduler_pkg.sv
// Shared encodings for the round-robin process scheduler:
// per-entry run state and the scheduler FSM states.
package process_scheduler_pkg;

  typedef enum logic [1:0] {
    ENT_EMPTY   = 2'd0,
    ENT_READY   = 2'd1,
    ENT_BLOCKED = 2'd2,
    ENT_DONE    = 2'd3
  } ent_state_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_SELECT = 3'd2,
    S_WAIT   = 3'd3,
    S_LOAD   = 3'd4
  } fsm_state_t;

endpackage

// File: rtl/process_scheduler_rr_arbiter.sv
// Rotating priority encoder: grants the first set mask bit after i_origin,
// wrapping modulo NPROC, so the origin entry itself is considered last.
module rr_arbiter #(
  parameter int NPROC = 4,
  parameter int PID_W = 2
) (
  input  logic [NPROC-1:0] i_mask,
  input  logic [PID_W-1:0] i_origin,
  output logic             o_grant_valid,
  output logic [PID_W-1:0] o_grant_id
);

  // Walk from the farthest candidate to the nearest so the nearest wins.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_id    = '0;
    for (int k = NPROC; k >= 1; k--) begin
      if (i_mask[i_origin + PID_W'(k)]) begin
        o_grant_valid = 1'b1;
        o_grant_id    = i_origin + PID_W'(k);
      end
    end
  end

endmodule

// File: rtl/process_scheduler.sv
// Round-robin process scheduler: process table, quantum counter and the
// IDLE/RUN/SELECT/WAIT/LOAD sequencer that issues switch requests to the CPU.
module process_scheduler
  import process_scheduler_pkg::*;
#(
  parameter int NPROC   = 4,
  parameter int PID_W   = 2,
  parameter int QUANTUM = 16,
  parameter int PC_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_create_valid,
  input  logic [PID_W-1:0] i_create_id,
  input  logic [PC_W-1:0]  i_create_pc,
  input  logic             i_instr_retire,
  input  logic [PC_W-1:0]  i_pc_in,
  input  logic             i_io_request,
  input  logic             i_io_done,
  input  logic [PID_W-1:0] i_io_id,
  input  logic             i_proc_end,
  output logic             o_switch_req,
  output logic [PC_W-1:0]  o_next_pc,
  output logic [PID_W-1:0] o_cur_proc,
  output logic             o_running,
  output logic             o_all_done
);

  localparam int             Q_W    = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
  localparam logic [Q_W-1:0] Q_LAST = Q_W'(QUANTUM - 1);

  ent_state_t       r_ent [NPROC];
  logic [PC_W-1:0]  r_pc  [NPROC];
  logic [Q_W-1:0]   r_qcnt;
  fsm_state_t       r_fsm, w_fsm_nxt;
  logic [PID_W-1:0] r_cur, r_origin;
  logic             r_switch, r_running, r_all_done;
  logic [PC_W-1:0]  r_next_pc;

  logic [NPROC-1:0] w_ready_mask;
  logic             w_live;
  logic             w_grant_valid;
  logic [PID_W-1:0] w_grant_id;
  logic             w_in_run, w_expire, w_event, w_search, w_load, w_start;

  always_comb begin
    w_ready_mask = '0;
    w_live       = 1'b0;
    for (int i = 0; i < NPROC; i++) begin
      w_ready_mask[i] = (r_ent[i] == ENT_READY);
      if (r_ent[i] == ENT_READY || r_ent[i] == ENT_BLOCKED) w_live = 1'b1;
    end
  end

  rr_arbiter #(.NPROC(NPROC), .PID_W(PID_W)) u_arb (
    .i_mask        (w_ready_mask),
    .i_origin      (r_origin),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  assign w_in_run = (r_fsm == S_RUN);
  assign w_expire = w_in_run && i_instr_retire && (r_qcnt == Q_LAST);
  assign w_event  = w_in_run && (i_proc_end || i_io_request || w_expire);
  assign w_search = (r_fsm == S_SELECT) || (r_fsm == S_WAIT);
  assign w_load   = w_search && w_grant_valid;
  assign w_start  = (r_fsm == S_IDLE) && i_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_fsm <= S_IDLE;
    else       r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE:   if (i_start) w_fsm_nxt = S_SELECT;
      S_RUN:    if (w_event) w_fsm_nxt = S_SELECT;
      S_SELECT: begin
        if (w_grant_valid) w_fsm_nxt = S_LOAD;
        else if (!w_live)  w_fsm_nxt = S_IDLE;
        else               w_fsm_nxt = S_WAIT;
      end
      S_WAIT:   if (w_grant_valid) w_fsm_nxt = S_LOAD;
      S_LOAD:   w_fsm_nxt = S_RUN;
      default:  w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_switch   <= 1'b0;
      r_next_pc  <= '0;
      r_cur      <= '0;
      r_origin   <= '0;
      r_running  <= 1'b0;
      r_all_done <= 1'b0;
      r_qcnt     <= '0;
    end else begin
      r_switch <= w_load;
      if (w_start) r_origin <= PID_W'(NPROC - 1);
      // Outputs are registered on the search hit so they are all valid in LOAD.
      if (w_load) begin
        r_cur     <= w_grant_id;
        r_origin  <= w_grant_id;
        r_next_pc <= r_pc[w_grant_id];
        r_running <= 1'b1;
      end else if (w_event) begin
        r_running <= 1'b0;
      end
      if (w_load || w_event)
        r_qcnt <= '0;
      else if (w_in_run && i_instr_retire && r_qcnt != Q_LAST)
        r_qcnt <= r_qcnt + Q_W'(1);
      if (i_start || i_create_valid)
        r_all_done <= 1'b0;
      else if (r_fsm == S_SELECT && !w_grant_valid && !w_live)
        r_all_done <= 1'b1;
    end
  end

  // Later assignments win: a running-process event overrides a same-edge io_done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPROC; i++) begin
        r_ent[i] <= ENT_EMPTY;
        r_pc[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NPROC; i++) begin
        if (i_io_done && i_io_id == PID_W'(i) && r_ent[i] == ENT_BLOCKED)
          r_ent[i] <= ENT_READY;
        if (i_create_valid && i_create_id == PID_W'(i) &&
            !(r_running && r_cur == PID_W'(i))) begin
          r_ent[i] <= ENT_READY;
          r_pc[i]  <= i_create_pc;
        end
        if (w_event && r_cur == PID_W'(i)) begin
          if (i_proc_end) begin
            r_ent[i] <= ENT_DONE;
          end else if (i_io_request) begin
            r_ent[i] <= ENT_BLOCKED;
            r_pc[i]  <= i_pc_in;
          end else begin
            r_ent[i] <= ENT_READY;
            r_pc[i]  <= i_pc_in;
          end
        end
      end
    end
  end

  assign o_switch_req = r_switch;
  assign o_next_pc    = r_next_pc;
  assign o_cur_proc   = r_cur;
  assign o_running    = r_running;
  assign o_all_done   = r_all_done;

endmodule
